leaf_out_sched: RTL and testbench
=================================

# leaf_out_sched

Output scheduler for a leaf shell. Shares the single BFT egress path between the NUM_OUT_PORTS user output streams (32-bit payload, vld/ack) of the user kernel. It uses round-robin arbitration, per-port destination configuration and per-port credit (freespace) tracking. Each accepted word becomes one 49-bit packet on the registered output to the BFT, and `resend` stalls the path.

## Interface
- PACKET_BITS, 49, packet width
- PAYLOAD_BITS, 32, user word width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, packet address field width
- NUM_OUT_PORTS, 4, user output streams arbitrated (2..15)
- NUM_BRAM_ADDR_BITS, 7, log2 of receiver buffer depth
- FREESPACE_UPDATE_SIZE, 64, credits added per freespace update

- clk  in  1  user/interface clock
- reset  in  1  asynchronous, active-high
- cfg_vld  in  1  one-cycle destination-config write
- cfg_sel  in  NUM_PORT_BITS  local output port written (0-based)
- cfg_leaf  in  NUM_LEAF_BITS  destination leaf for that port
- cfg_port  in  NUM_PORT_BITS  destination port for that port
- fs_vld  in  1  one-cycle freespace update
- fs_sel  in  NUM_PORT_BITS  local output port credited
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  concatenated payloads; port 0 in LSBs
- vld_user2interface  in  NUM_OUT_PORTS  per-port word valid
- ack_interface2user  out  NUM_OUT_PORTS  per-port accept
- resend  in  1  stall: no grants while high
- dout_leaf_interface2bft  out  PACKET_BITS  registered packet

## Operation
- Packet layout:
  - [48] valid
  - [47:43] dest leaf
  - [42:39] dest port
  - [38:32] addr
  - [31:0] payload
- Per-port state:
  - cfg_ok bit, leaf, port
  - credit counter, NUM_BRAM_ADDR_BITS+1 wide
  - addr counter, NUM_ADDR_BITS wide
- Eligible port i: vld[i] & cfg_ok[i] & credit[i]!=0 & !resend.
- Round-robin arbitration:
  - Search starts at last_grant+1, modulo NUM_OUT_PORTS; the first eligible port is granted.
  - At most one grant per cycle. last_grant updates only when a grant is made.
- ack[i] = grant[i]. This is combinational from vld and state, in the same cycle. A word is transferred when vld[i]&ack[i].
- On transfer from port i:
  - credit[i] decrements.
  - addr[i] increments, wrapping 127→0.
  - The packet {1, leaf[i], port[i], addr[i] (pre-increment), payload[i]} is registered to dout.
- Idle cycles: dout is all zeros. In a cycle with no transfer and resend low, dout loads 0.
- resend high: dout holds its current value, no acks, counters frozen.
- Freespace update: credit[fs_sel] += FREESPACE_UPDATE_SIZE, saturating at 2^NUM_BRAM_ADDR_BITS.
  - Simultaneous consume on the same port gives a net +63, also saturating.
  - fs_sel ≥ NUM_OUT_PORTS is ignored.
- Config write:
  - Sets cfg_ok, leaf and port for cfg_sel, and clears addr[cfg_sel].
  - A grant in the same cycle to the same port uses the old leaf/port. The addr clear wins over the increment.
  - Credits are unaffected.
  - cfg_sel ≥ NUM_OUT_PORTS is ignored.

## Timing
- Reset values:
  - ack 0, dout 0.
  - All credits 0, cfg_ok 0, addr 0.
  - last_grant = NUM_OUT_PORTS-1, so port 0 wins the first tie.
- Latency: the word accepted in cycle N appears on dout in cycle N+1. Throughput is 1 packet/cycle.
- cfg and fs writes take effect for arbitration from the cycle after they are asserted.
- Reset mid-stream:
  - All state clears immediately (async).
  - An in-flight dout packet is dropped. The user must re-present un-acked words.
- Credit 0 blocks a port without affecting the other ports (no head-of-line coupling).

## Structure
- Shared package `leaf_pkg`: packet field offsets/widths and the FREESPACE_UPDATE_SIZE default, also used by the receive path.
- Sub-module `rr_arbiter` (NUM_OUT_PORTS requests, last_grant in → one-hot grant out; purely combinational). The state registers stay in the parent.

## Test plan
- After reset, cfg port0→(leaf 3, port 2), fs port0, then vld[0] for 3 words A,B,C → ack[0] on 3 consecutive cycles; dout = {1,3,2,addr 0/1/2,A/B/C} one cycle later; credit[0]=61.
- All 4 ports configured and credited, all vld held high → grants 0,1,2,3,0,... one per cycle; each port's addr increments independently.
- Port 1 given only one fs update, 70 words offered → exactly 64 acks, then ack[1] stays 0; a further fs_vld restores grants the following cycle.
- Assert resend for 5 cycles mid-stream → no acks, dout frozen at its last packet; after release arbitration resumes at last_grant+1.
- fs_vld and a transfer on port 2 in the same cycle, starting from credit 100 → credit 128 (saturated), not 163.
- Config write to port 0 in the same cycle as its grant with addr=9 → that packet carries the old leaf/port and addr 9; the next packet carries the new leaf/port and addr 0.

Source files
------------

// File: rtl/leaf_pkg.sv
// Shared leaf-shell constants: packet field layout and credit defaults used by
// both the egress scheduler and the receive path.
package leaf_pkg;

    localparam int unsigned LEAF_PACKET_BITS           = 49;
    localparam int unsigned LEAF_PAYLOAD_BITS          = 32;
    localparam int unsigned LEAF_NUM_LEAF_BITS         = 5;
    localparam int unsigned LEAF_NUM_PORT_BITS         = 4;
    localparam int unsigned LEAF_NUM_ADDR_BITS         = 7;
    localparam int unsigned LEAF_NUM_BRAM_ADDR_BITS    = 7;
    localparam int unsigned LEAF_FREESPACE_UPDATE_SIZE = 64;

    localparam int unsigned PKT_PAYLOAD_LSB = 0;
    localparam int unsigned PKT_ADDR_LSB    = PKT_PAYLOAD_LSB + LEAF_PAYLOAD_BITS;
    localparam int unsigned PKT_PORT_LSB    = PKT_ADDR_LSB + LEAF_NUM_ADDR_BITS;
    localparam int unsigned PKT_LEAF_LSB    = PKT_PORT_LSB + LEAF_NUM_PORT_BITS;
    localparam int unsigned PKT_VALID_BIT   = PKT_LEAF_LSB + LEAF_NUM_LEAF_BITS;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDX_BITS = 4
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [IDX_BITS-1:0] last_grant,
    output logic [NUM_REQ-1:0]  grant,
    output logic [IDX_BITS-1:0] grant_idx,
    output logic                grant_vld
);

    logic                found;
    logic [NUM_REQ-1:0]  grant_c;
    logic [IDX_BITS-1:0] idx_c;

    // Offset k walks the ring starting just past last_grant; the inner loop
    // keeps every request index constant after unrolling.
    always_comb begin
        found   = 1'b0;
        grant_c = '0;
        idx_c   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == (32'(last_grant) + k) % NUM_REQ)) begin
                    found      = 1'b1;
                    grant_c[i] = 1'b1;
                    idx_c      = IDX_BITS'(i);
                end
            end
        end
        grant     = grant_c;
        grant_idx = idx_c;
        grant_vld = found;
    end

endmodule

// File: rtl/leaf_out_sched.sv
// Leaf-shell egress scheduler: round-robin over user output streams with
// per-port destination config and credit tracking, one registered packet/cycle.
module leaf_out_sched
    import leaf_pkg::*;
#(
    parameter int unsigned PACKET_BITS           = LEAF_PACKET_BITS,
    parameter int unsigned PAYLOAD_BITS          = LEAF_PAYLOAD_BITS,
    parameter int unsigned NUM_LEAF_BITS         = LEAF_NUM_LEAF_BITS,
    parameter int unsigned NUM_PORT_BITS         = LEAF_NUM_PORT_BITS,
    parameter int unsigned NUM_ADDR_BITS         = LEAF_NUM_ADDR_BITS,
    parameter int unsigned NUM_OUT_PORTS         = 4,
    parameter int unsigned NUM_BRAM_ADDR_BITS    = LEAF_NUM_BRAM_ADDR_BITS,
    parameter int unsigned FREESPACE_UPDATE_SIZE = LEAF_FREESPACE_UPDATE_SIZE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cfg_vld,
    input  logic [NUM_PORT_BITS-1:0]          cfg_sel,
    input  logic [NUM_LEAF_BITS-1:0]          cfg_leaf,
    input  logic [NUM_PORT_BITS-1:0]          cfg_port,
    input  logic                              fs_vld,
    input  logic [NUM_PORT_BITS-1:0]          fs_sel,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]          vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]          ack_interface2user,
    input  logic                              resend,
    output logic [PACKET_BITS-1:0]            dout_leaf_interface2bft
);

    localparam int unsigned CW         = NUM_BRAM_ADDR_BITS + 1;
    localparam int unsigned CREDIT_MAX = 1 << NUM_BRAM_ADDR_BITS;

    logic                     cfg_ok [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] leaf_q [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] port_q [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr_q [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_q [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_d [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] last_grant;

    logic [NUM_OUT_PORTS-1:0] req;
    logic [NUM_OUT_PORTS-1:0] grant;
    logic [NUM_OUT_PORTS-1:0] cfg_hit;
    logic [NUM_OUT_PORTS-1:0] fs_hit;
    logic [NUM_PORT_BITS-1:0] grant_idx;
    logic                     grant_vld;
    logic [PACKET_BITS-1:0]   pkt;

    always_comb begin
        req     = '0;
        cfg_hit = '0;
        fs_hit  = '0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            req[i]     = vld_user2interface[i] && cfg_ok[i] && (credit_q[i] != '0) && !resend;
            cfg_hit[i] = cfg_vld && (cfg_sel == NUM_PORT_BITS'(i));
            fs_hit[i]  = fs_vld && (fs_sel == NUM_PORT_BITS'(i));
        end
    end

    rr_arbiter #(
        .NUM_REQ  (NUM_OUT_PORTS),
        .IDX_BITS (NUM_PORT_BITS)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_vld  (grant_vld)
    );

    assign ack_interface2user = grant;

    // Grant is one-hot, so OR-ing the granted port's fields avoids a variable array index.
    always_comb begin
        pkt = '0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            if (grant[i]) begin
                pkt = pkt | PACKET_BITS'({1'b1, leaf_q[i], port_q[i], addr_q[i],
                                          din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]});
            end
        end
    end

    // Credit sum is formed wide so a same-cycle refill and consume saturate once.
    always_comb begin
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            int unsigned sum;
            sum = 32'(credit_q[i]) + (fs_hit[i] ? FREESPACE_UPDATE_SIZE : 0) - (grant[i] ? 1 : 0);
            credit_d[i] = (sum > CREDIT_MAX) ? CW'(CREDIT_MAX) : CW'(sum);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_leaf_interface2bft <= '0;
            last_grant              <= NUM_PORT_BITS'(NUM_OUT_PORTS - 1);
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
                cfg_ok[i]   <= 1'b0;
                leaf_q[i]   <= '0;
                port_q[i]   <= '0;
                addr_q[i]   <= '0;
                credit_q[i] <= '0;
            end
        end else begin
            if (!resend) begin
                dout_leaf_interface2bft <= grant_vld ? pkt : '0;
            end
            if (grant_vld) begin
                last_grant <= grant_idx;
            end
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_q[i] <= credit_d[i];
                if (cfg_hit[i]) begin
                    cfg_ok[i] <= 1'b1;
                    leaf_q[i] <= cfg_leaf;
                    port_q[i] <= cfg_port;
                    addr_q[i] <= '0;
                end else if (grant[i]) begin
                    addr_q[i] <= addr_q[i] + NUM_ADDR_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_leaf_out_sched.sv
// Directed bench for leaf_out_sched: per-cycle vector table plus hand-written
// credit, saturation, config-collision and reset sequences.
module tb_leaf_out_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_vld;
    logic [3:0]   cfg_sel;
    logic [4:0]   cfg_leaf;
    logic [3:0]   cfg_port;
    logic         fs_vld;
    logic [3:0]   fs_sel;
    logic [127:0] din;
    logic [3:0]   vld;
    logic [3:0]   ack;
    logic         resend;
    logic [48:0]  dout;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    leaf_out_sched #(
        .NUM_OUT_PORTS (4)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cfg_vld                 (cfg_vld),
        .cfg_sel                 (cfg_sel),
        .cfg_leaf                (cfg_leaf),
        .cfg_port                (cfg_port),
        .fs_vld                  (fs_vld),
        .fs_sel                  (fs_sel),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .resend                  (resend),
        .dout_leaf_interface2bft (dout)
    );

    typedef struct {
        logic         cv;
        logic [3:0]   cs;
        logic [4:0]   cl;
        logic [3:0]   cp;
        logic         fv;
        logic [3:0]   fsel;
        logic [3:0]   v;
        logic [127:0] d;
        logic         rs;
        logic [3:0]   eack;
        logic [48:0]  edout;
    } vec_t;

    function automatic vec_t mk(input logic cv, input logic [3:0] cs, input logic [4:0] cl,
                                input logic [3:0] cp, input logic fv, input logic [3:0] fsel,
                                input logic [3:0] v, input logic [127:0] d, input logic rs,
                                input logic [3:0] eack, input logic [48:0] edout);
        vec_t t;
        t.cv = cv; t.cs = cs; t.cl = cl; t.cp = cp; t.fv = fv; t.fsel = fsel;
        t.v = v; t.d = d; t.rs = rs; t.eack = eack; t.edout = edout;
        return t;
    endfunction

    function automatic logic [48:0] pk(input logic [4:0] l, input logic [3:0] p,
                                       input logic [6:0] a, input logic [31:0] d);
        return {1'b1, l, p, a, d};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [3:0] cs, input logic [4:0] cl,
                         input logic [3:0] cp, input logic fv, input logic [3:0] fsel,
                         input logic [3:0] v, input logic [127:0] d, input logic rs);
        cfg_vld = cv; cfg_sel = cs; cfg_leaf = cl; cfg_port = cp;
        fs_vld = fv; fs_sel = fsel; vld = v; din = d; resend = rs;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 5'd0, 4'd0, 1'b0, 4'd0, 4'd0, '0, 1'b0);
    endtask

    // Samples ack mid-cycle, then dout just after the following rising edge.
    task automatic step(output logic [3:0] a, output logic [48:0] d);
        #1 a = ack;
        @(posedge clk);
        #1 d = dout;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #2;
        chk("reset_ack", 64'(ack), 64'h0);
        chk("reset_dout", 64'(dout), 64'h0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    localparam logic [31:0] WA = 32'hAAAA_0001;
    localparam logic [31:0] WB = 32'hBBBB_0002;
    localparam logic [31:0] WC = 32'hCCCC_0003;
    localparam logic [31:0] P0 = 32'hC0DE_0000;
    localparam logic [31:0] P1 = 32'hC0DE_0001;
    localparam logic [31:0] P2 = 32'hC0DE_0002;
    localparam logic [31:0] P3 = 32'hC0DE_0003;

    initial begin
        vec_t         tbl[$];
        logic [127:0] pd;
        logic [3:0]   a;
        logic [48:0]  d;
        int           c0, c1, c2;
        logic [31:0]  pay;

        pd = {P3, P2, P1, P0};
        // cfg port0 -> (3,2), credit it, then three words A/B/C
        tbl.push_back(mk(1, 0, 3, 2, 0, 0, 4'h0, '0, 0, 4'h0, '0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4'h0, '0, 0, 4'h0, '0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h1, {96'h0, WA}, 0, 4'h1, pk(3, 2, 0, WA)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h1, {96'h0, WB}, 0, 4'h1, pk(3, 2, 1, WB)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h1, {96'h0, WC}, 0, 4'h1, pk(3, 2, 2, WC)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h0, '0, 0, 4'h0, '0));
        // configure and credit ports 1..3
        tbl.push_back(mk(1, 1, 1, 5, 1, 1, 4'h0, '0, 0, 4'h0, '0));
        tbl.push_back(mk(1, 2, 2, 6, 1, 2, 4'h0, '0, 0, 4'h0, '0));
        tbl.push_back(mk(1, 3, 4, 7, 1, 3, 4'h0, '0, 0, 4'h0, '0));
        // all valid: round robin resumes after port 0 (last grant)
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, pd, 0, 4'h2, pk(1, 5, 0, P1)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, pd, 0, 4'h4, pk(2, 6, 0, P2)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, pd, 0, 4'h8, pk(4, 7, 0, P3)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, pd, 0, 4'h1, pk(3, 2, 3, P0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, pd, 0, 4'h2, pk(1, 5, 1, P1)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, pd, 0, 4'h4, pk(2, 6, 1, P2)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, pd, 0, 4'h8, pk(4, 7, 1, P3)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, pd, 0, 4'h1, pk(3, 2, 4, P0)));
        // resend for 5 cycles: no acks, dout frozen
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, pd, 1, 4'h0, pk(3, 2, 4, P0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, pd, 0, 4'h2, pk(1, 5, 2, P1)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h0, '0, 0, 4'h0, '0));

        reset = 1'b0;
        idle();
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].cv, tbl[i].cs, tbl[i].cl, tbl[i].cp, tbl[i].fv, tbl[i].fsel,
                  tbl[i].v, tbl[i].d, tbl[i].rs);
            step(a, d);
            chk($sformatf("tbl%0d_ack", i), 64'(a), 64'(tbl[i].eack));
            chk($sformatf("tbl%0d_dout", i), 64'(d), 64'(tbl[i].edout));
        end

        // Credit exhaustion on port 1 (64 credits) while port 0 (128) keeps flowing
        do_reset();
        drive(1, 0, 1, 1, 1, 0, 4'h0, '0, 0); step(a, d);
        drive(1, 1, 9, 1, 1, 0, 4'h0, '0, 0); step(a, d);
        drive(0, 0, 0, 0, 1, 1, 4'h0, '0, 0); step(a, d);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 150; i++) begin
            drive(0, 0, 0, 0, 0, 0, 4'h3, pd, 0);
            step(a, d);
            if (a[0]) c0++;
            if (a[1]) c1++;
        end
        chk("exhaust_port1_acks", 64'(c1), 64'd64);
        chk("exhaust_port0_acks", 64'(c0), 64'd86);
        drive(0, 0, 0, 0, 0, 0, 4'h3, pd, 0); step(a, d);
        chk("exhaust_probe_ack", 64'(a), 64'h1);
        drive(0, 0, 0, 0, 1, 1, 4'h3, pd, 0); step(a, d);
        chk("refill_cycle_ack", 64'(a), 64'h1);
        drive(0, 0, 0, 0, 0, 0, 4'h3, pd, 0); step(a, d);
        chk("refill_next_ack", 64'(a), 64'h2);
        chk("refill_next_dout", 64'(d), 64'(pk(9, 1, 64, P1)));

        // Saturation on port 2: credit 100 plus refill and consume -> 128; addr wraps
        do_reset();
        drive(1, 2, 6, 3, 1, 2, 4'h0, '0, 0); step(a, d);
        drive(0, 0, 0, 0, 1, 2, 4'h0, '0, 0); step(a, d);
        c2 = 0;
        for (int i = 0; i < 28; i++) begin
            pay = 32'h5A5A_0000 + 32'(i);
            drive(0, 0, 0, 0, 0, 0, 4'h4, {32'h0, pay, 64'h0}, 0);
            step(a, d);
            if (a[2]) begin
                chk("sat_pre_dout", 64'(d), 64'(pk(6, 3, 7'(c2), pay)));
                c2++;
            end
        end
        chk("sat_pre_acks", 64'(c2), 64'd28);
        pay = 32'h5A5A_FFFF;
        drive(0, 0, 0, 0, 1, 2, 4'h4, {32'h0, pay, 64'h0}, 0); step(a, d);
        chk("sat_same_cycle_ack", 64'(a), 64'h4);
        chk("sat_same_cycle_dout", 64'(d), 64'(pk(6, 3, 28, pay)));
        c2 = 0;
        for (int i = 0; i < 200; i++) begin
            pay = 32'h6B6B_0000 + 32'(i);
            drive(0, 0, 0, 0, 0, 0, 4'h4, {32'h0, pay, 64'h0}, 0);
            step(a, d);
            if (a[2]) begin
                chk("sat_post_dout", 64'(d), 64'(pk(6, 3, 7'(29 + c2), pay)));
                c2++;
            end
        end
        chk("sat_post_acks", 64'(c2), 64'd128);

        // Out-of-range selects, config/grant collision, async reset mid-stream
        do_reset();
        drive(1, 4, 1, 1, 1, 4, 4'h0, '0, 0); step(a, d);
        drive(0, 0, 0, 0, 0, 0, 4'h1, {96'h0, WA}, 0); step(a, d);
        chk("oob_cfg_ignored", 64'(a), 64'h0);
        drive(1, 0, 3, 2, 1, 4, 4'h0, '0, 0); step(a, d);
        drive(0, 0, 0, 0, 0, 0, 4'h1, {96'h0, WA}, 0); step(a, d);
        chk("oob_fs_ignored", 64'(a), 64'h0);
        drive(0, 0, 0, 0, 1, 0, 4'h0, '0, 0); step(a, d);
        c0 = 0;
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, 0, 0, 0, 4'h1, {96'h0, WA}, 0); step(a, d);
            if (a[0]) c0++;
        end
        chk("coll_pre_acks", 64'(c0), 64'd9);
        drive(1, 0, 7, 9, 0, 0, 4'h1, {96'h0, WB}, 0); step(a, d);
        chk("coll_ack", 64'(a), 64'h1);
        chk("coll_old_dest", 64'(d), 64'(pk(3, 2, 9, WB)));
        drive(0, 0, 0, 0, 0, 0, 4'h1, {96'h0, WC}, 0); step(a, d);
        chk("coll_new_dest", 64'(d), 64'(pk(7, 9, 0, WC)));
        reset = 1'b1;
        #1;
        chk("midreset_dout", 64'(dout), 64'h0);
        chk("midreset_ack", 64'(ack), 64'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 4'h1, {96'h0, WC}, 0); step(a, d);
        chk("postreset_unconfigured", 64'(a), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
